// File: rtl/cam_response_encoder.sv
// CAM response path: registers array read/search results, priority-encodes
// match lines and returns ordered responses through a 2-entry FIFO.
module cam_response_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  read_valid_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic                  search_valid_i,
  input  logic [DEPTH-1:0]      match_lines_i,
  output logic                  in_ready_o,
  output logic                  drop_o,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  resp_kind_o,
  output logic                  resp_hit_o,
  output logic                  resp_multi_o,
  output logic [ADDR_WIDTH-1:0] resp_index_o,
  output logic [DATA_WIDTH-1:0] resp_data_o
);

  typedef struct packed {
    logic                  kind;
    logic                  hit;
    logic                  multi;
    logic [ADDR_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  // Stage-1 capture register
  logic                  r_s1_valid;
  logic                  r_s1_kind;
  logic [DEPTH-1:0]      r_s1_match;
  logic [ADDR_WIDTH-1:0] r_s1_index;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_drop;

  // Response FIFO
  resp_t                 r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_present;
  logic                  w_accept;
  logic [2:0]            w_occ;
  resp_t                 w_enc;
  resp_t                 w_head;

  assign w_pop     = resp_valid_o & resp_ready_i;
  assign w_push    = r_s1_valid;
  assign w_present = read_valid_i | search_valid_i;
  // Occupancy after this edge's pop; one free slot is needed for what stage 1 will push.
  assign w_occ      = {1'b0, r_count} + {2'b00, r_s1_valid} - {2'b00, w_pop};
  assign in_ready_o = (w_occ <= 3'd1);
  assign w_accept   = w_present & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_kind  <= 1'b0;
      r_s1_match <= '0;
      r_s1_index <= '0;
      r_s1_data  <= '0;
      r_drop     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_s1_valid <= w_accept;
      r_drop     <= w_present & (~in_ready_o | (read_valid_i & search_valid_i));
      if (w_accept) begin
        r_s1_kind  <= search_valid_i;
        r_s1_match <= match_lines_i;
        r_s1_index <= read_index_i;
        r_s1_data  <= read_data_i;
      end
    end
  end

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    w_enc = '0;
    if (!r_s1_kind) begin
      w_enc.hit   = 1'b1;
      w_enc.index = r_s1_index;
      w_enc.data  = r_s1_data;
    end else begin
      w_enc.kind  = 1'b1;
      w_enc.hit   = |r_s1_match;
      w_enc.multi = (r_s1_match & (r_s1_match - DEPTH'(1))) != '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_s1_match[k]) w_enc.index = ADDR_WIDTH'(k);
      end
    end
  end

  // NOTE: FIFO payload is not reset; it is only observable behind a nonzero count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_enc;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign resp_valid_o = (r_count != 2'd0);
  assign w_head       = resp_valid_o ? r_mem[r_rd_ptr] : '0;
  assign resp_kind_o  = w_head.kind;
  assign resp_hit_o   = w_head.hit;
  assign resp_multi_o = w_head.multi;
  assign resp_index_o = w_head.index;
  assign resp_data_o  = w_head.data;
  assign drop_o       = r_drop;

endmodule

// File: tb/tb_cam_response_encoder.sv
// Bench for cam_response_encoder: queue-based response model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cam_response_encoder;

  logic        clk;
  logic        rst_n;
  logic        read_valid;
  logic [4:0]  read_index;
  logic [31:0] read_data;
  logic        search_valid;
  logic [31:0] match_lines;
  logic        in_ready;
  logic        drop;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_kind;
  logic        resp_hit;
  logic        resp_multi;
  logic [4:0]  resp_index;
  logic [31:0] resp_data;

  cam_response_encoder dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .read_valid_i   (read_valid),
    .read_index_i   (read_index),
    .read_data_i    (read_data),
    .search_valid_i (search_valid),
    .match_lines_i  (match_lines),
    .in_ready_o     (in_ready),
    .drop_o         (drop),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_kind_o    (resp_kind),
    .resp_hit_o     (resp_hit),
    .resp_multi_o   (resp_multi),
    .resp_index_o   (resp_index),
    .resp_data_o    (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted result sits in one queue (capture stage + FIFO)
  // and becomes visible two cycles after the cycle it was presented.
  typedef struct {
    logic        kind;
    logic        hit;
    logic        multi;
    logic [4:0]  index;
    logic [31:0] data;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   exp_drop = 0;
  int   drop_cnt = 0;
  int   hs_cnt = 0;

  function automatic exp_t model_result(input logic rv, input logic [4:0] ri,
                                        input logic [31:0] rd, input logic sv,
                                        input logic [31:0] ml, input int when);
    exp_t e;
    e.rdy = when;
    if (sv) begin
      e.kind  = 1'b1;
      e.hit   = (ml != 0);
      e.multi = ($countones(ml) > 1);
      e.data  = 32'd0;
      e.index = 5'd0;
      for (int b = 31; b >= 0; b--) if (ml[b]) e.index = 5'(b);
    end else begin
      e.kind  = 1'b0;
      e.hit   = 1'b1;
      e.multi = 1'b0;
      e.index = ri;
      e.data  = rd;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    bit exp_valid, pop, exp_ready, presented;
    int occ;
    if (!rst_n) begin
      q.delete();
      exp_drop = 0;
      check("rst_valid", 64'(resp_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_drop", 64'(drop), 64'd0);
      check("rst_index", 64'(resp_index), 64'd0);
    end else begin
      exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      check("valid", 64'(resp_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("kind", 64'(resp_kind), 64'(q[0].kind));
        check("hit", 64'(resp_hit), 64'(q[0].hit));
        check("multi", 64'(resp_multi), 64'(q[0].multi));
        check("index", 64'(resp_index), 64'(q[0].index));
        check("data", 64'(resp_data), 64'(q[0].data));
      end else begin
        check("idle_fields", 64'({resp_kind, resp_hit, resp_multi, resp_index}), 64'd0);
      end
      pop = exp_valid && resp_ready;
      occ = q.size() - int'(pop);
      exp_ready = (occ <= 1);
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("drop", 64'(drop), 64'(exp_drop));
      if (drop === 1'b1) drop_cnt++;
      if (resp_valid === 1'b1 && resp_ready === 1'b1) hs_cnt++;
      presented = read_valid || search_valid;
      exp_drop  = presented && (!exp_ready || (read_valid && search_valid));
      if (pop) void'(q.pop_front());
      if (presented && exp_ready)
        q.push_back(model_result(read_valid, read_index, read_data,
                                 search_valid, match_lines, cyc + 2));
    end
    cyc++;
  end

  task automatic present(input logic rv, input logic [4:0] ri, input logic [31:0] rd,
                         input logic sv, input logic [31:0] ml);
    @(posedge clk); #1;
    read_valid = rv; read_index = ri; read_data = rd;
    search_valid = sv; match_lines = ml;
  endtask

  task automatic idle();
    present(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Waits (bounded) for a response, then pins it against literal values.
  task automatic expect_resp(input string name, input logic kind, input logic hit,
                             input logic multi, input logic [4:0] index, input logic [31:0] data);
    bit found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) found = 1;
    end
    check({name, "_seen"}, 64'(found), 64'd1);
    if (found) begin
      check({name, "_kind"}, 64'(resp_kind), 64'(kind));
      check({name, "_hit"}, 64'(resp_hit), 64'(hit));
      check({name, "_multi"}, 64'(resp_multi), 64'(multi));
      check({name, "_index"}, 64'(resp_index), 64'(index));
      check({name, "_data"}, 64'(resp_data), 64'(data));
    end
  endtask

  initial begin
    int d0, h0;
    read_valid = 0; read_index = 0; read_data = 0;
    search_valid = 0; match_lines = 0; resp_ready = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", 64'(resp_valid), 64'd0);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Two-hit search: lowest row 5, multi set
    present(1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_0120);
    idle();
    expect_resp("s120", 1'b1, 1'b1, 1'b1, 5'd5, 32'd0);
    repeat (2) @(posedge clk);

    present(1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_0000);
    idle();
    expect_resp("s0", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);

    present(1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0000);
    idle();
    expect_resp("s31", 1'b1, 1'b1, 1'b0, 5'd31, 32'd0);
    repeat (2) @(posedge clk);

    present(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 32'd0);
    idle();
    expect_resp("rd7", 1'b0, 1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);

    // Eight back-to-back searches at full throughput
    d0 = drop_cnt; h0 = hs_cnt;
    for (int i = 0; i < 8; i++) present(1'b0, 5'd0, 32'd0, 1'b1, (32'h3 << (3 * i)));
    idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("b2b_responses", 64'(hs_cnt - h0), 64'd8);
    check("b2b_drops", 64'(drop_cnt - d0), 64'd0);

    // Back-pressure: third search finds the block full
    d0 = drop_cnt;
    @(posedge clk); #1 resp_ready = 1'b0;
    present(1'b0, 5'd0, 32'd0, 1'b1, 32'h2);
    present(1'b0, 5'd0, 32'd0, 1'b1, 32'h4);
    present(1'b0, 5'd0, 32'd0, 1'b1, 32'h8);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    idle();
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("bp_first_index", 64'({resp_valid, resp_index}), 64'({1'b1, 5'd1}));
    @(negedge clk);
    check("bp_second_index", 64'({resp_valid, resp_index}), 64'({1'b1, 5'd2}));
    @(negedge clk);
    check("bp_drained", 64'(resp_valid), 64'd0);
    check("bp_drops", 64'(drop_cnt - d0), 64'd1);

    // Read and search together: search wins, read is dropped
    d0 = drop_cnt;
    present(1'b1, 5'd9, 32'h1234_5678, 1'b1, 32'h4);
    idle();
    expect_resp("both", 1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    repeat (4) @(posedge clk);
    check("both_drops", 64'(drop_cnt - d0), 64'd1);

    // Reset with two entries queued
    @(posedge clk); #1 resp_ready = 1'b0;
    present(1'b0, 5'd0, 32'd0, 1'b1, 32'h10);
    present(1'b1, 5'd3, 32'hCAFE_0000, 1'b0, 32'd0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queued_before_reset", 64'(resp_valid), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(resp_valid), 64'd0);
    check("async_reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; resp_ready = 1'b1;
    h0 = hs_cnt;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("no_stale_responses", 64'(hs_cnt - h0), 64'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_response_encoder.md
Name: cam_response_encoder

Overview:
- Sits on the output side of the CAM array. It is the return path for the CAM decoder, which turns read/write/search requests into one-hot row enables.
- Collects per-row match lines and read data from the array and priority-encodes search results into a row index.
- Reports hit, multi-hit, index and data as ordered responses on a valid/ready interface, through a 1-stage capture register and a 2-entry response FIFO.

Parameters:
- DATA_WIDTH, 32, width of a CAM row / read data.
- ADDR_WIDTH, 5, width of a row index.
- DEPTH, 1<<ADDR_WIDTH, number of rows (width of match vector).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- read_valid_i  input  1  array read result present this cycle.
- read_index_i  input  ADDR_WIDTH  row that was read.
- read_data_i  input  DATA_WIDTH  row contents.
- search_valid_i  input  1  array search result present this cycle.
- match_lines_i  input  DEPTH  per-row match, bit k = row k matched.
- in_ready_o  output  1  block can accept a result this cycle.
- drop_o  output  1  one-cycle pulse: a presented result was discarded.
- resp_valid_o  output  1  response at FIFO head.
- resp_ready_i  input  1  consumer accepts head.
- resp_kind_o  output  1  0 = read, 1 = search.
- resp_hit_o  output  1  search: any match; read: always 1.
- resp_multi_o  output  1  search: two or more matches; read: 0.
- resp_index_o  output  ADDR_WIDTH  search: lowest matching row (0 if none); read: read_index_i.
- resp_data_o  output  DATA_WIDTH  read: read_data_i; search: 0.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - Stage-1 register and FIFO cleared.
  - resp_valid_o=0; all resp_* outputs=0; drop_o=0; in_ready_o=1.
  - Reset mid-operation discards every pending result with no response.
- Accept rule:
  - Result presented when read_valid_i or search_valid_i is 1.
  - Accepted on a rising edge where in_ready_o=1.
- Simultaneous read_valid_i and search_valid_i: search is taken, read is discarded, drop_o=1 next cycle.
- Presented while in_ready_o=0: discarded, drop_o=1 next cycle. drop_o is registered, high exactly one cycle per drop event.
- in_ready_o = (fifo_count + s1_valid - pop) <= 1, where pop = resp_valid_o & resp_ready_i. It depends combinationally on resp_ready_i; the block sustains one result per cycle when resp_ready_i stays high.
- Stage 1 registers the raw inputs: kind, match vector or index/data.
- Encode from stage 1:
  - hit = OR of match bits.
  - index = lowest set bit position.
  - multi = more than one bit set.
  - The encoded result is pushed into the FIFO on the next edge.
- Latency: result presented at cycle N gives resp_valid_o=1 at cycle N+2 when the FIFO is empty.
- FIFO:
  - 2 entries, strict in-order.
  - resp_* driven from head, stable while resp_valid_o=1 and resp_ready_i=0.
  - Push and pop in the same cycle allowed at any count, including 2.
  - No overflow is possible, by the in_ready_o rule.
  - Pointers are 1 bit and wrap. A count register (0..2) drives resp_valid_o = (count != 0).
- Empty FIFO with resp_ready_i=1: no pop, nothing changes.
- Write traffic is not seen by this block.

Test Plan:
- Reset release → resp_valid_o=0, in_ready_o=1, drop_o=0; assert rst_n_i mid-stream with 2 entries queued → resp_valid_o=0 immediately, no stale response after release.
- Search with match_lines_i=0x00000120, resp_ready_i=1 → 2 cycles later one response: kind=1, hit=1, index=5, multi=1, data=0.
- Search with match_lines_i=0 → hit=0, index=0, multi=0; search with 0x80000000 → hit=1, index=31, multi=0.
- Read with index 7, data 0xDEADBEEF → kind=0, hit=1, index=7, data=0xDEADBEEF; then 8 back-to-back searches with ready=1 → 8 responses on consecutive cycles, no drops.
- resp_ready_i=0, 3 searches on consecutive cycles (indices 1,2,3 single-hot) → first two accepted, in_ready_o=0 on the third, drop_o pulses once. Raise ready → responses 1 then 2, then resp_valid_o=0.
- read_valid_i and search_valid_i together (match 0x4, read index 9) → single search response, index=2; drop_o pulses once.
